vscale_dmem_bridge: RTL and testbench

Data-memory bridge sitting directly downstream of the vscale core's data port. Converts the core's split-phase access (address/control in the DX stage, store data and load data in the WB stage) into a single-outstanding valid/ready request with a response handshake. Drives the core's `dmem_wait` stall and `dmem_badmem_e` fault inputs.

---
 rtl/vscale_dmem_bridge_pkg.sv | 23 ++
 rtl/vscale_dmem_wstrb_gen.sv | 46 ++++
 rtl/vscale_dmem_bridge.sv | 133 +++++++++++++
 tb/tb_vscale_dmem_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_dmem_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vscale_dmem_bridge_pkg                                                   |
// | Shared definitions for the vscale data-memory bridge:                    |
// |   - bridge state encodings (2-bit): IDLE=0, REQ=1, RESP=2, ERR=3         |
// |   - dmem_size encodings used by the core: byte, half, word               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package vscale_dmem_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } dmem_state_t;

   localparam logic [2:0] c_size_byte = 3'd0;
   localparam logic [2:0] c_size_half = 3'd1;
   localparam logic [2:0] c_size_word = 3'd2;

endpackage
`default_nettype wire

// File: rtl/vscale_dmem_wstrb_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vscale_dmem_wstrb_gen                                                    |
// | Turns an access size and byte offset into a bus byte-lane strobe and     |
// | flags accesses that are not naturally aligned.                           |
// | Ports:                                                                   |
// |   size       in  3  dmem_size encoding (byte/half/word)                  |
// |   addr_lo    in  2  byte offset within the word                          |
// |   wen        in  1  store when 1; loads produce an all-zero strobe       |
// |   wstrb      out 4  byte-lane write strobe                               |
// |   misaligned out 1  half at odd address, or word not on 4-byte boundary  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module vscale_dmem_wstrb_gen
   import vscale_dmem_bridge_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr_lo,
   input  logic       wen,
   output logic [3:0] wstrb,
   output logic       misaligned
);

   always_comb begin
      wstrb      = 4'h0;
      misaligned = 1'b0;
      case (size)
         c_size_byte: wstrb = 4'b0001 << addr_lo;
         c_size_half: begin
            // A half at offset 3 shifts lane 4 off the end; the bus sees lane 3 only.
            wstrb      = 4'b0011 << addr_lo;
            misaligned = addr_lo[0];
         end
         c_size_word: begin
            wstrb      = 4'hF;
            misaligned = |addr_lo;
         end
         default: ;
      endcase
      if (!wen) begin
         wstrb = 4'h0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vscale_dmem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vscale_dmem_bridge                                                       |
// | Bridges the vscale core's split-phase data port (control in DX, data in  |
// | WB) onto a single-outstanding valid/ready request bus with a response    |
// | handshake. Generates the core's dmem_wait stall and dmem_badmem_e fault. |
// | Ports:                                                                   |
// |   clk, reset_n                  clock, async active-low reset            |
// |   dmem_en/wen/size/addr         core access request (DX)                 |
// |   dmem_wdata_delayed            store data (WB, held while stalled)      |
// |   dmem_rdata, dmem_badmem_e     load data / fault to WB                  |
// |   dmem_wait                     stall to core                            |
// |   bus_req_valid/ready/wen/addr/wdata/wstrb   request channel             |
// |   bus_resp_valid/rdata/err                   response channel            |
// | Build option: VSCALE_DMEM_MISALIGN_CHECK_EN - when defined, misaligned   |
// |   half/word accesses raise a fault instead of reaching the bus.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module vscale_dmem_bridge
   import vscale_dmem_bridge_pkg::*;
#(
   parameter int XPR_LEN = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               dmem_en,
   input  logic               dmem_wen,
   input  logic [2:0]         dmem_size,
   input  logic [XPR_LEN-1:0] dmem_addr,
   input  logic [XPR_LEN-1:0] dmem_wdata_delayed,
   output logic [XPR_LEN-1:0] dmem_rdata,
   output logic               dmem_wait,
   output logic               dmem_badmem_e,
   output logic               bus_req_valid,
   input  logic               bus_req_ready,
   output logic               bus_req_wen,
   output logic [XPR_LEN-1:0] bus_req_addr,
   output logic [XPR_LEN-1:0] bus_req_wdata,
   output logic [3:0]         bus_req_wstrb,
   input  logic               bus_resp_valid,
   input  logic [XPR_LEN-1:0] bus_resp_rdata,
   input  logic               bus_resp_err
);

   dmem_state_t          r_state;
   dmem_state_t          w_state_next;
   dmem_state_t          w_launch_state;
   logic                 r_wen;
   logic [XPR_LEN-3:0]   r_word_addr;
   logic [3:0]           r_wstrb;
   logic [3:0]           w_wstrb;
   logic                 w_misaligned;
   logic                 w_accept;
   logic                 w_resp_take;

   // Strobe and alignment are decoded from the DX-stage request and captured
   // at accept, so the registered request carries only what the bus needs.
   vscale_dmem_wstrb_gen u_wstrb_gen (
      .size       (dmem_size),
      .addr_lo    (dmem_addr[1:0]),
      .wen        (dmem_wen),
      .wstrb      (w_wstrb),
      .misaligned (w_misaligned)
   );

   // Responses are only honoured in RESP; anything arriving earlier is dropped.
   assign w_resp_take = (r_state == ST_RESP) && bus_resp_valid;
   assign dmem_wait   = (r_state == ST_REQ) || ((r_state == ST_RESP) && !bus_resp_valid);
   assign w_accept    = dmem_en && !dmem_wait;

`ifdef VSCALE_DMEM_MISALIGN_CHECK_EN
   assign w_launch_state = w_misaligned ? ST_ERR : ST_REQ;
`else
   logic w_unused_misaligned;
   assign w_unused_misaligned = w_misaligned;
   assign w_launch_state      = ST_REQ;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_next = w_launch_state;
         end
         ST_REQ: begin
            if (bus_req_ready) w_state_next = ST_RESP;
         end
         ST_RESP: begin
            // Completing response and next accept in one cycle: no idle bubble.
            if (bus_resp_valid) w_state_next = w_accept ? w_launch_state : ST_IDLE;
         end
`ifdef VSCALE_DMEM_MISALIGN_CHECK_EN
         ST_ERR: begin
            w_state_next = w_accept ? w_launch_state : ST_IDLE;
         end
`endif
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_wen       <= 1'b0;
         r_word_addr <= '0;
         r_wstrb     <= 4'h0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_wen       <= dmem_wen;
            r_word_addr <= dmem_addr[XPR_LEN-1:2];
            r_wstrb     <= w_wstrb;
         end
      end
   end

   // Request fields come straight from registers (and the core's held store
   // data), so they stay stable for as long as valid waits on ready.
   assign bus_req_valid = (r_state == ST_REQ);
   assign bus_req_wen   = bus_req_valid && r_wen;
   assign bus_req_addr  = bus_req_valid ? {r_word_addr, 2'b00} : '0;
   assign bus_req_wdata = bus_req_valid ? dmem_wdata_delayed : '0;
   assign bus_req_wstrb = bus_req_valid ? r_wstrb : 4'h0;

   assign dmem_rdata    = w_resp_take ? bus_resp_rdata : '0;
`ifdef VSCALE_DMEM_MISALIGN_CHECK_EN
   assign dmem_badmem_e = (w_resp_take && bus_resp_err) || (r_state == ST_ERR);
`else
   assign dmem_badmem_e = w_resp_take && bus_resp_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vscale_dmem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vscale_dmem_bridge                                                    |
// | Directed scenarios followed by random traffic, each cycle compared       |
// | against a transaction-level reference of the bridge.                     |
// | Honours VSCALE_DMEM_MISALIGN_CHECK_EN the same way as the design.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vscale_dmem_bridge;

   localparam int XPR_LEN = 32;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              dmem_en;
   logic              dmem_wen;
   logic [2:0]        dmem_size;
   logic [31:0]       dmem_addr;
   logic [31:0]       dmem_wdata_delayed;
   logic [31:0]       dmem_rdata;
   logic              dmem_wait;
   logic              dmem_badmem_e;
   logic              bus_req_valid;
   logic              bus_req_ready;
   logic              bus_req_wen;
   logic [31:0]       bus_req_addr;
   logic [31:0]       bus_req_wdata;
   logic [3:0]        bus_req_wstrb;
   logic              bus_resp_valid;
   logic [31:0]       bus_resp_rdata;
   logic              bus_resp_err;

   always #5 clk = ~clk;

   vscale_dmem_bridge #(.XPR_LEN(XPR_LEN)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .dmem_en            (dmem_en),
      .dmem_wen           (dmem_wen),
      .dmem_size          (dmem_size),
      .dmem_addr          (dmem_addr),
      .dmem_wdata_delayed (dmem_wdata_delayed),
      .dmem_rdata         (dmem_rdata),
      .dmem_wait          (dmem_wait),
      .dmem_badmem_e      (dmem_badmem_e),
      .bus_req_valid      (bus_req_valid),
      .bus_req_ready      (bus_req_ready),
      .bus_req_wen        (bus_req_wen),
      .bus_req_addr       (bus_req_addr),
      .bus_req_wdata      (bus_req_wdata),
      .bus_req_wstrb      (bus_req_wstrb),
      .bus_resp_valid     (bus_resp_valid),
      .bus_resp_rdata     (bus_resp_rdata),
      .bus_resp_err       (bus_resp_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: one outstanding transaction, whether it has been handed to
   // the bus yet, and a one-cycle pending fault.
   bit          m_busy;
   bit          m_sent;
   bit          m_fault;
   bit          m_wen;
   logic [2:0]  m_size;
   logic [31:0] m_addr;

   // Last observed outputs, for directed checks.
   logic        obs_valid, obs_wait, obs_bad;
   logic [31:0] obs_addr, obs_rdata;
   logic [3:0]  obs_wstrb;

   function automatic logic [3:0] ref_strb(bit wen, logic [2:0] size, logic [31:0] addr);
      int nbytes;
      int mask;
      if (!wen) return 4'h0;
      if (size == 3'd2) return 4'hF;
      nbytes = (size == 3'd0) ? 1 : 2;
      mask   = ((1 << nbytes) - 1) << addr[1:0];
      return mask[3:0];
   endfunction

   function automatic bit ref_misaligned(logic [2:0] size, logic [31:0] addr);
      return (size == 3'd1 && (addr % 2) != 0) || (size == 3'd2 && (addr % 4) != 0);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy  = 0;
      m_sent  = 0;
      m_fault = 0;
      m_wen   = 0;
      m_size  = 3'd0;
      m_addr  = 32'h0;
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_valid"}, bus_req_valid, 0);
      chk({tag, "_wait"},  dmem_wait, 0);
      chk({tag, "_bad"},   dmem_badmem_e, 0);
      chk({tag, "_rdata"}, dmem_rdata, 0);
      chk({tag, "_wen"},   bus_req_wen, 0);
      chk({tag, "_addr"},  bus_req_addr, 0);
      chk({tag, "_wdata"}, bus_req_wdata, 0);
      chk({tag, "_wstrb"}, bus_req_wstrb, 0);
   endtask

   // One clock: compare outputs mid-cycle, then advance the reference at the edge.
   task automatic step();
      bit done;
      bit exp_wait;
      bit accept;
      @(negedge clk);
      obs_valid = bus_req_valid;
      obs_wait  = dmem_wait;
      obs_bad   = dmem_badmem_e;
      obs_addr  = bus_req_addr;
      obs_rdata = dmem_rdata;
      obs_wstrb = bus_req_wstrb;
      done     = m_busy && m_sent && bus_resp_valid;
      exp_wait = m_busy && !done;
      chk("valid", bus_req_valid, m_busy && !m_sent);
      chk("wait", dmem_wait, exp_wait);
      if (m_busy && !m_sent) begin
         chk("req_addr", bus_req_addr, m_addr & ~32'h3);
         chk("req_wdata", bus_req_wdata, dmem_wdata_delayed);
         chk("req_wstrb", bus_req_wstrb, ref_strb(m_wen, m_size, m_addr));
         chk("req_wen", bus_req_wen, m_wen);
      end
      if (done) begin
         chk("rdata", dmem_rdata, bus_resp_rdata);
         chk("badmem", dmem_badmem_e, bus_resp_err);
      end else if (m_fault) begin
         chk("badmem_fault", dmem_badmem_e, 1);
      end else if (!(m_busy && m_sent)) begin
         chk("badmem_idle", dmem_badmem_e, 0);
         chk("rdata_idle", dmem_rdata, 0);
      end
      @(posedge clk);
      accept  = dmem_en && !exp_wait;
      m_fault = 0;
      if (done) m_busy = 0;
      else if (m_busy && !m_sent && bus_req_ready) m_sent = 1;
      if (accept) begin
`ifdef VSCALE_DMEM_MISALIGN_CHECK_EN
         if (ref_misaligned(dmem_size, dmem_addr)) begin
            m_fault = 1;
         end else begin
            m_busy = 1; m_sent = 0; m_wen = dmem_wen; m_size = dmem_size; m_addr = dmem_addr;
         end
`else
         m_busy = 1; m_sent = 0; m_wen = dmem_wen; m_size = dmem_size; m_addr = dmem_addr;
`endif
      end
      #1;
   endtask

   task automatic core_req(bit en, bit wen, logic [2:0] size, logic [31:0] addr);
      dmem_en = en; dmem_wen = wen; dmem_size = size; dmem_addr = addr;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      core_req(0, 0, 3'd0, 32'h0);
      dmem_wdata_delayed = 32'h0;
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b0;
      bus_resp_rdata = 32'h0;
      bus_resp_err   = 1'b0;
      model_reset();
      #2;
      chk_all_zero("reset");
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;

      // Word load at 0x1004, response two cycles after accept.
      core_req(1, 0, 3'd2, 32'h1004);
      step();
      core_req(0, 0, 3'd0, 32'h0);
      bus_req_ready = 1;
      step();
      chk("t1_addr", obs_addr, 32'h1004);
      chk("t1_wstrb", obs_wstrb, 4'h0);
      chk("t1_wait_req", obs_wait, 1);
      bus_req_ready = 0;
      bus_resp_valid = 1; bus_resp_rdata = 32'hDEADBEEF;
      step();
      chk("t1_wait_resp", obs_wait, 0);
      chk("t1_rdata", obs_rdata, 32'hDEADBEEF);
      bus_resp_valid = 0;
      step();

      // Byte store at 0x2003 with ready held low for three cycles.
      core_req(1, 1, 3'd0, 32'h2003);
      step();
      core_req(0, 0, 3'd0, 32'h0);
      dmem_wdata_delayed = 32'h000000AA;
      for (int k = 0; k < 4; k++) begin
         bus_req_ready = (k == 3);
         step();
         chk("t2_valid", obs_valid, 1);
         chk("t2_addr", obs_addr, 32'h2000);
         chk("t2_wstrb", obs_wstrb, 4'b1000);
      end
      bus_req_ready = 0;
      bus_resp_valid = 1; bus_resp_rdata = 32'h0;
      step();
      bus_resp_valid = 0;

      // Back-to-back: load response with a new store accept in the same cycle.
      core_req(1, 0, 3'd2, 32'h0000_0040);
      step();
      core_req(0, 0, 3'd0, 32'h0);
      bus_req_ready = 1;
      step();
      bus_req_ready = 0;
      bus_resp_valid = 1; bus_resp_rdata = 32'h1234_5678;
      core_req(1, 1, 3'd2, 32'h0000_0044);
      step();
      chk("t3_wait", obs_wait, 0);
      core_req(0, 0, 3'd0, 32'h0);
      bus_resp_valid = 0;
      dmem_wdata_delayed = 32'hCAFE_F00D;
      bus_req_ready = 1;
      step();
      chk("t3_valid", obs_valid, 1);
      chk("t3_addr", obs_addr, 32'h44);
      bus_req_ready = 0;
      bus_resp_valid = 1;
      step();
      bus_resp_valid = 0;

      // Error response: fault for exactly one cycle, then idle.
      core_req(1, 0, 3'd2, 32'h0000_0100);
      step();
      core_req(0, 0, 3'd0, 32'h0);
      bus_req_ready = 1;
      step();
      bus_req_ready = 0;
      bus_resp_valid = 1; bus_resp_err = 1;
      step();
      chk("t4_bad", obs_bad, 1);
      bus_resp_valid = 0; bus_resp_err = 0;
      step();
      chk("t4_bad_after", obs_bad, 0);
      chk("t4_idle_valid", obs_valid, 0);
      chk("t4_idle_wait", obs_wait, 0);

      // Misaligned word access at 0x3002.
      core_req(1, 0, 3'd2, 32'h3002);
      step();
      core_req(0, 0, 3'd0, 32'h0);
`ifdef VSCALE_DMEM_MISALIGN_CHECK_EN
      step();
      chk("t5_valid", obs_valid, 0);
      chk("t5_bad", obs_bad, 1);
      chk("t5_wait", obs_wait, 0);
      step();
      chk("t5_wait_after", obs_wait, 0);
`else
      bus_req_ready = 1;
      step();
      chk("t5_valid", obs_valid, 1);
      chk("t5_addr", obs_addr, 32'h3000);
      bus_req_ready = 0;
      bus_resp_valid = 1;
      step();
      bus_resp_valid = 0;
`endif

      // Reset asserted while waiting for a response.
      core_req(1, 0, 3'd2, 32'h0000_0200);
      step();
      core_req(0, 0, 3'd0, 32'h0);
      bus_req_ready = 1;
      step();
      bus_req_ready = 0;
      #1;
      reset_n = 1'b0;
      #1;
      chk_all_zero("t6_reset");
      model_reset();
      #2;
      reset_n = 1'b1;
      bus_resp_valid = 1; bus_resp_rdata = 32'h5555_AAAA;
      step();
      chk("t6_rdata_ignored", obs_rdata, 0);
      chk("t6_wait", obs_wait, 0);
      bus_resp_valid = 0;
      step();

      // Random traffic against the reference.
      for (int i = 0; i < 2000; i++) begin
         core_req($urandom_range(0, 1), $urandom_range(0, 1),
                  3'($urandom_range(0, 2)), $urandom);
         dmem_wdata_delayed = $urandom;
         bus_req_ready  = ($urandom_range(0, 2) != 0);
         bus_resp_valid = $urandom_range(0, 1);
         bus_resp_rdata = $urandom;
         bus_resp_err   = ($urandom_range(0, 7) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
